// File: rtl/mixcol_seq.sv
// rtl/mixcol_seq.sv - multi-cycle AES MixColumns engine, COLS_PER_CYCLE columns per RUN cycle.
// Optional InvMixColumns support is built when MIXCOL_INVERSE_EN is defined.
module mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mixcol_enable,
  input  logic         mixcol_inverse,
  input  logic [127:0] olddata,
  output logic [127:0] newdata,
  output logic         mixcol_busy,
  output logic         mixcol_finished
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [1:0]     r_col_cnt;
  logic [127:0]   r_work;
  logic [127:0]   w_work_next;
  logic [127:0]   r_newdata;
  logic           w_last_col;

`ifdef MIXCOL_INVERSE_EN
  logic           r_mode;
`else
  logic           w_unused_inverse;
  assign w_unused_inverse = mixcol_inverse;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Columns are packed row 0 in the top byte: {a0, a1, a2, a3}.
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef MIXCOL_INVERSE_EN
  // 9 = 8+1, B = 8+2+1, D = 8+4+1, E = 8+4+2, each from one xtime chain per byte.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  assign w_last_col = (r_col_cnt == 2'(4 - COLS_PER_CYCLE));

  always_comb begin
    logic [1:0]  lane_col;
    logic [31:0] col_in;
    logic [31:0] col_out;
    w_work_next = r_work;
    lane_col    = 2'd0;
    col_in      = 32'd0;
    col_out     = 32'd0;
    for (int l = 0; l < COLS_PER_CYCLE; l++) begin
      lane_col = r_col_cnt + 2'(l);
      for (int r = 0; r < 4; r++) begin
        col_in[31-8*r -: 8] = r_work[32*r + 8*lane_col +: 8];
      end
`ifdef MIXCOL_INVERSE_EN
      col_out = r_mode ? mix_inv(col_in) : mix_fwd(col_in);
`else
      col_out = mix_fwd(col_in);
`endif
      for (int r = 0; r < 4; r++) begin
        w_work_next[32*r + 8*lane_col +: 8] = col_out[31-8*r -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (mixcol_enable) w_state_next = S_RUN;
      S_RUN:   if (w_last_col) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mixcol_busy     = (r_state == S_RUN) || (r_state == S_DONE);
    mixcol_finished = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_cnt <= 2'd0;
      r_work    <= 128'd0;
      r_newdata <= 128'd0;
`ifdef MIXCOL_INVERSE_EN
      r_mode    <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && mixcol_enable) begin
        r_work    <= olddata;
        r_col_cnt <= 2'd0;
`ifdef MIXCOL_INVERSE_EN
        r_mode    <= mixcol_inverse;
`endif
      end else if (r_state == S_RUN) begin
        r_work    <= w_work_next;
        r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
        if (w_last_col) r_newdata <= w_work_next;
      end
    end
  end

  assign newdata = r_newdata;

endmodule

// File: tb/tb_mixcol_seq.sv
// tb/tb_mixcol_seq.sv - random and directed checks of mixcol_seq at COLS_PER_CYCLE 1, 2 and 4.
// Inverse-mode expectations follow MIXCOL_INVERSE_EN.
module tb_mixcol_seq;

`ifdef MIXCOL_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         inv;
  logic [127:0] od;
  logic [127:0] nd [3];
  logic [2:0]   busy;
  logic [2:0]   fin;

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] prev [3];

  always #5 clk = ~clk;

  mixcol_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .mixcol_enable(en), .mixcol_inverse(inv), .olddata(od),
    .newdata(nd[0]), .mixcol_busy(busy[0]), .mixcol_finished(fin[0]));
  mixcol_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .mixcol_enable(en), .mixcol_inverse(inv), .olddata(od),
    .newdata(nd[1]), .mixcol_busy(busy[1]), .mixcol_finished(fin[1]));
  mixcol_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .mixcol_enable(en), .mixcol_inverse(inv), .olddata(od),
    .newdata(nd[2]), .mixcol_busy(busy[2]), .mixcol_finished(fin[2]));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [7:0] p;
    x = {1'b0, a};
    p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic mode);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (mode && INV_EN) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else                base = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'd0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - r + 4) % 4], d[32*k + 8*c +: 8]);
        res[32*r + 8*c +: 8] = acc;
      end
    end
    return res;
  endfunction

  // Each argument lists one column top row first, e.g. 32'hdb135345.
  function automatic logic [127:0] pack_cols(input logic [31:0] c0, input logic [31:0] c1,
                                             input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0]  cs [4];
    logic [127:0] res;
    cs = '{c0, c1, c2, c3};
    res = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[32*r + 8*c +: 8] = cs[c][31-8*r -: 8];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(input string tag, input logic [127:0] d, input logic m, input logic [127:0] exp);
    int lat [3];
    int cnt [3];
    od  = d;
    inv = m;
    en  = 1'b1;
    @(posedge clk); #1;
    en  = 1'b0;
    od  = rand128();
    inv = ~m;
    lat = '{0, 0, 0};
    cnt = '{0, 0, 0};
    for (int i = 0; i < 3; i++) check_eq($sformatf("%s_hold_p%0d", tag, 1 << i), nd[i], prev[i]);
    for (int n = 1; n <= 12; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (fin[i]) begin
          cnt[i]++;
          if (lat[i] == 0) lat[i] = n;
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_data_p%0d", tag, 1 << i), nd[i], exp);
      check_eq($sformatf("%s_lat_p%0d", tag, 1 << i), 128'(lat[i]), 128'(4 / (1 << i) + 1));
      check_eq($sformatf("%s_pulses_p%0d", tag, 1 << i), 128'(cnt[i]), 128'd1);
      prev[i] = exp;
    end
  endtask

  task automatic held_enable(input logic m);
    logic [127:0] d [25];
    int s, l;
    for (int e = 0; e < 25; e++) d[e] = rand128();
    inv = m;
    od  = d[0];
    en  = 1'b1;
    for (int e = 0; e < 24; e++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        l = 4 / (1 << i);
        s = l + 2;
        check_eq($sformatf("held_fin_p%0d_e%0d", 1 << i, e), 128'(fin[i]), 128'((e % s) == l));
        if ((e % s) == l)
          check_eq($sformatf("held_data_p%0d_e%0d", 1 << i, e), nd[i], ref_mix(d[e - l], m));
      end
      od = d[e + 1];
      if (e == 23) en = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      s = 4 / (1 << i) + 2;
      prev[i] = ref_mix(d[(23 / s) * s], m);
    end
  endtask

  initial begin
    logic [127:0] kv_in, kv_out, xt_in, xt_out, d;
    logic         m;
    int           stray;
    rst = 1'b1; en = 1'b0; inv = 1'b0; od = 128'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_data_p%0d", 1 << i), nd[i], 128'd0);
      check_eq($sformatf("rst_flags_p%0d", 1 << i), {126'd0, busy[i], fin[i]}, 128'd0);
      prev[i] = 128'd0;
    end

    kv_in  = pack_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c);
    kv_out = pack_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8);
    run_op("known_fwd", kv_in, 1'b0, kv_out);
    if (INV_EN) run_op("known_inv", kv_out, 1'b1, kv_in);

    xt_in  = pack_cols(32'hd4d4d4d5, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6);
    xt_out = pack_cols(32'hd5d5d7d6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6);
    run_op("xtime", xt_in, 1'b0, xt_out);

    for (int t = 0; t < 6; t++) begin
      d = rand128();
      m = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", t), d, m, ref_mix(d, m));
    end

    held_enable(1'b0);
    held_enable(1'b1);

    // Abort on the second RUN cycle of the COLS_PER_CYCLE=1 instance.
    od = rand128(); inv = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("abort_data_p%0d", 1 << i), nd[i], 128'd0);
      check_eq($sformatf("abort_flags_p%0d", 1 << i), {126'd0, busy[i], fin[i]}, 128'd0);
      prev[i] = 128'd0;
    end
    stray = 0;
    for (int n = 0; n < 8; n++) begin
      if (fin != 3'b000) stray++;
      @(posedge clk); #1;
    end
    check_eq("abort_no_pulse", 128'(stray), 128'd0);
    d = rand128();
    run_op("after_abort", d, 1'b0, ref_mix(d, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
